// File: rtl/audio_pkg.sv
// Shared constants and gain-state encoding for the 44.1 kHz I2S transmit path.
package audio_pkg;

    localparam int FRAME_CYCLES = 128;
    localparam int SLOT_BITS    = 32;
    localparam int PHASE_W      = $clog2(FRAME_CYCLES);

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        RAMP_DN = 2'd1,
        MUTED   = 2'd2,
        RAMP_UP = 2'd3
    } gain_state_t;

endpackage

// File: rtl/pcm_gain.sv
// Signed sample times unsigned gain, rescaled so g = 2**UNITY_SHIFT is bit-exact.
module pcm_gain
    import audio_pkg::*;
#(
    parameter int UNITY_SHIFT = 5
) (
    input  logic signed [SLOT_BITS-1:0] x,
    input  logic        [UNITY_SHIFT:0] g,
    output logic signed [SLOT_BITS-1:0] y
);

    // Sample width plus gain magnitude bits plus a sign bit for the zero-extended gain.
    localparam int PROD_W = SLOT_BITS + UNITY_SHIFT + 2;

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] g_ext;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        x_ext = {{(PROD_W-SLOT_BITS){x[SLOT_BITS-1]}}, x};
        g_ext = {{(PROD_W-UNITY_SHIFT-1){1'b0}}, g};
        prod  = x_ext * g_ext;
        y     = SLOT_BITS'(prod >>> UNITY_SHIFT);
    end

endmodule

// File: rtl/i2s_tx_441.sv
// I2S transmitter for one 44.1 kHz stereo frame per 128 bck882 cycles,
// with sample hand-off, underrun/overrun tracking and a soft-mute gain ramp.
module i2s_tx_441
    import audio_pkg::*;
#(
    parameter int UNITY_SHIFT     = 5,
    parameter bit UNDERRUN_REPEAT = 1'b1
) (
    input  logic        bck882,
    input  logic        reset,
    input  logic [31:0] pcm_left,
    input  logic [31:0] pcm_right,
    input  logic        pcm_valid,
    input  logic        mute,
    output logic        bck_out,
    output logic        lrck,
    output logic        sdata,
    output logic        muted,
    output logic        overrun,
    output logic [7:0]  underrun_cnt
);

    localparam int                GAIN_W = UNITY_SHIFT + 1;
    localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(2 ** UNITY_SHIFT);

    logic [PHASE_W-1:0]     phase;
    logic [PHASE_W-1:0]     phase_nx;
    logic                   load;
    logic                   have_sample;
    logic [2*SLOT_BITS-1:0] shreg;
    logic [SLOT_BITS-1:0]   hold_l, hold_r;
    logic                   pending;
    logic [SLOT_BITS-1:0]   src_l, src_r;
    logic [SLOT_BITS-1:0]   gained_l, gained_r;
    gain_state_t            state, state_nx;
    logic [GAIN_W-1:0]      gain, gain_nx;

    assign phase_nx    = phase + PHASE_W'(1);
    assign load        = (phase == PHASE_W'(FRAME_CYCLES - 1));
    assign have_sample = pending | pcm_valid;
    assign bck_out     = phase[0];

    // With nothing pending, the hold registers still contain the last loaded sample,
    // so they double as the repeat source on underrun.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        src_l = hold_l;
        src_r = hold_r;
        if (pcm_valid) begin
            src_l = pcm_left;
            src_r = pcm_right;
        end else if (!pending && !UNDERRUN_REPEAT) begin
            src_l = '0;
            src_r = '0;
        end
    end

    // The next gain must be known combinationally: the frame loaded at this
    // boundary already uses it.
    always_comb begin
        state_nx = state;
        gain_nx  = gain;
        if (mute && state != MUTED) begin
            gain_nx  = gain - GAIN_W'(1);
            state_nx = (gain_nx == '0) ? MUTED : RAMP_DN;
        end else if (!mute && state != PLAY) begin
            gain_nx  = gain + GAIN_W'(1);
            state_nx = (gain_nx == UNITY) ? PLAY : RAMP_UP;
        end
    end

    pcm_gain #(.UNITY_SHIFT(UNITY_SHIFT)) u_gain_l (
        .x (src_l),
        .g (gain_nx),
        .y (gained_l)
    );

    pcm_gain #(.UNITY_SHIFT(UNITY_SHIFT)) u_gain_r (
        .x (src_r),
        .g (gain_nx),
        .y (gained_r)
    );

    always_ff @(posedge bck882) begin
        if (reset) begin
            // NOTE: the datapath registers are reset too, so a frame aborted by reset is followed by silence.
            phase        <= '0;
            lrck         <= 1'b0;
            sdata        <= 1'b0;
            shreg        <= '0;
            hold_l       <= '0;
            hold_r       <= '0;
            pending      <= 1'b0;
            overrun      <= 1'b0;
            underrun_cnt <= '0;
            state        <= PLAY;
            gain         <= UNITY;
            muted        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand side sees pre-edge values.
            phase <= phase_nx;
            lrck  <= phase_nx[PHASE_W-1];

            // Data advances only on the edge where bck_out falls; the load edge
            // also emits the previous frame's last bit, giving the one-bit I2S delay.
            if (phase[0]) begin
                sdata <= shreg[2*SLOT_BITS-1];
                shreg <= load ? {gained_l, gained_r} : (shreg << 1);
            end

            if (pcm_valid) begin
                hold_l <= pcm_left;
                hold_r <= pcm_right;
            end
            if (pcm_valid && pending) begin
                overrun <= 1'b1;
            end

            if (load) begin
                pending <= 1'b0;
                state   <= state_nx;
                gain    <= gain_nx;
                muted   <= (state_nx == MUTED);
                if (!have_sample && underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                end
            end else if (pcm_valid) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_441.sv
// Directed bench for i2s_tx_441: frame decode, underrun, overrun, bypass, soft-mute ramp, mid-frame reset.
module tb_i2s_tx_441;

    logic        bck882 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcm_left = '0;
    logic [31:0] pcm_right = '0;
    logic        pcm_valid = 1'b0;
    logic        mute = 1'b0;

    logic       bck_out_a, lrck_a, sdata_a, muted_a, overrun_a;
    logic [7:0] cnt_a;
    logic       bck_out_z, lrck_z, sdata_z, muted_z, overrun_z;
    logic [7:0] cnt_z;

    i2s_tx_441 #(.UNITY_SHIFT(5), .UNDERRUN_REPEAT(1'b1)) dut (
        .bck882       (bck882),
        .reset        (reset),
        .pcm_left     (pcm_left),
        .pcm_right    (pcm_right),
        .pcm_valid    (pcm_valid),
        .mute         (mute),
        .bck_out      (bck_out_a),
        .lrck         (lrck_a),
        .sdata        (sdata_a),
        .muted        (muted_a),
        .overrun      (overrun_a),
        .underrun_cnt (cnt_a)
    );

    i2s_tx_441 #(.UNITY_SHIFT(5), .UNDERRUN_REPEAT(1'b0)) dut_z (
        .bck882       (bck882),
        .reset        (reset),
        .pcm_left     (pcm_left),
        .pcm_right    (pcm_right),
        .pcm_valid    (pcm_valid),
        .mute         (mute),
        .bck_out      (bck_out_z),
        .lrck         (lrck_z),
        .sdata        (sdata_z),
        .muted        (muted_z),
        .overrun      (overrun_z),
        .underrun_cnt (cnt_z)
    );

    always #5 bck882 = ~bck882;

    // Reference frame phase kept by the bench, restarted by reset.
    int tb_p = 0;
    always @(posedge bck882) tb_p <= reset ? 0 : (tb_p + 1) % 128;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t        vecs[5];
    logic [63:0] fa, fz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge bck882);
    endtask

    task automatic goto_phase(input int k);
        int n = 0;
        while (tb_p != k && n < 256) begin
            step();
            n++;
        end
        if (tb_p != k) begin
            total++;
            bad++;
            $display("FAIL goto_phase: at %0d expected %0d", tb_p, k);
        end
    endtask

    task automatic do_reset();
        pcm_valid = 1'b0;
        mute = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic strobe(input int k, input logic [31:0] l, input logic [31:0] r);
        goto_phase(k);
        pcm_left = l;
        pcm_right = r;
        pcm_valid = 1'b1;
        step();
        pcm_valid = 1'b0;
    endtask

    // Decodes the frame carried by slots 1..63 of the current frame plus slot 0 of the next,
    // optionally strobing a new sample at p=10. Returns at p=1 of the next frame.
    task automatic run_frame(input bit feed, input logic [31:0] l, input logic [31:0] r,
                             output logic [63:0] fra, output logic [63:0] frz);
        int   fmt = 0;
        int   idx;
        logic prev_a = 1'b0;
        goto_phase(1);
        fra = '0;
        frz = '0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (feed && tb_p == 10) begin
                pcm_left = l;
                pcm_right = r;
                pcm_valid = 1'b1;
            end else begin
                pcm_valid = 1'b0;
            end
            if (bck_out_a !== ((tb_p % 2) == 1)) fmt++;
            if (lrck_a !== (tb_p >= 64)) fmt++;
            if (lrck_z !== (tb_p >= 64)) fmt++;
            if ((tb_p % 2) == 0) begin
                prev_a = sdata_a;
            end else begin
                if (sdata_a !== prev_a) fmt++;
                idx = (i == 127) ? 0 : 64 - tb_p / 2;
                fra[idx] = sdata_a;
                frz[idx] = sdata_z;
            end
        end
        check("frame_format", 64'(fmt), 64'd0);
    endtask

    function automatic int exp_gain(input int k);
        if (k <= 33) return 33 - k;
        if (k <= 41) return 0;
        if (k <= 73) return k - 41;
        return 32;
    endfunction

    initial begin
        vecs[0] = '{32'h80000001, 32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF};
        vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        vecs[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[3] = '{32'h12345678, 32'h87654321, 32'h12345678, 32'h87654321};
        vecs[4] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

        // Reset state.
        repeat (3) step();
        check("rst_bck_out", 64'(bck_out_a), 64'd0);
        check("rst_lrck", 64'(lrck_a), 64'd0);
        check("rst_sdata", 64'(sdata_a), 64'd0);
        check("rst_muted", 64'(muted_a), 64'd0);
        check("rst_overrun", 64'(overrun_a), 64'd0);
        check("rst_underrun", 64'(cnt_a), 64'd0);
        reset = 1'b0;

        // Table: sample strobed at p=10 appears unchanged (unity gain) in the next frame.
        run_frame(1'b1, vecs[0].l, vecs[0].r, fa, fz);
        check("post_reset_zeros", fa, 64'd0);
        for (int i = 0; i < 5; i++) begin
            run_frame(i < 4, vecs[(i < 4) ? i + 1 : i].l, vecs[(i < 4) ? i + 1 : i].r, fa, fz);
            check($sformatf("vec%0d", i), fa, {vecs[i].exp_l, vecs[i].exp_r});
            check($sformatf("vec%0d_z", i), fz, {vecs[i].exp_l, vecs[i].exp_r});
        end
        check("table_underrun", 64'(cnt_a), 64'd1);
        check("table_overrun", 64'(overrun_a), 64'd0);

        // Underrun: repeat vs zeros, then saturation.
        do_reset();
        run_frame(1'b1, 32'h13579BDF, 32'h2468ACE0, fa, fz);
        run_frame(1'b0, 32'h0, 32'h0, fa, fz);
        check("ur_first", fa, 64'h13579BDF_2468ACE0);
        check("ur_first_z", fz, 64'h13579BDF_2468ACE0);
        for (int j = 0; j < 2; j++) begin
            run_frame(1'b0, 32'h0, 32'h0, fa, fz);
            check($sformatf("ur_repeat%0d", j), fa, 64'h13579BDF_2468ACE0);
            check($sformatf("ur_zero%0d", j), fz, 64'd0);
        end
        check("ur_cnt3", 64'(cnt_a), 64'd3);
        check("ur_cnt3_z", 64'(cnt_z), 64'd3);
        repeat (253) run_frame(1'b0, 32'h0, 32'h0, fa, fz);
        check("ur_saturate", 64'(cnt_a), 64'd255);

        // Overrun: second strobe in the same frame wins and sets the sticky flag.
        do_reset();
        strobe(5, 32'h11111111, 32'h22222222);
        check("ovr_first", 64'(overrun_a), 64'd0);
        strobe(60, 32'hCAFEF00D, 32'h0BADBEEF);
        check("ovr_second", 64'(overrun_a), 64'd1);
        run_frame(1'b0, 32'h0, 32'h0, fa, fz);
        check("ovr_data", fa, 64'hCAFEF00D_0BADBEEF);

        // Strobe on the load cycle bypasses the hold path and is not an underrun.
        do_reset();
        strobe(127, 32'h76543210, 32'hFEDCBA98);
        check("byp_no_underrun", 64'(cnt_a), 64'd0);
        run_frame(1'b0, 32'h0, 32'h0, fa, fz);
        check("byp_data", fa, 64'h76543210_FEDCBA98);
        check("byp_data_z", fz, 64'h76543210_FEDCBA98);
        run_frame(1'b0, 32'h0, 32'h0, fa, fz);
        check("byp_repeat", fa, 64'h76543210_FEDCBA98);
        check("byp_pending_clr_z", fz, 64'd0);
        check("byp_cnt", 64'(cnt_a), 64'd2);

        // Soft mute: 40 frames of mute, then release.
        do_reset();
        for (int k = 0; k < 76; k++) begin
            logic [31:0] el;
            mute = (k >= 1 && k <= 40);
            run_frame(1'b1, 32'h40000000, 32'hC0000000, fa, fz);
            if (k >= 1) begin
                el = 32'(exp_gain(k)) * 32'h02000000;
                check($sformatf("ramp%0d", k), fa, {el, 32'd0 - el});
            end
            check($sformatf("muted%0d", k), 64'(muted_a), 64'(k >= 32 && k <= 40));
        end

        // Reset at p=70 in the middle of a ramp-down.
        mute = 1'b1;
        repeat (3) run_frame(1'b1, 32'h40000000, 32'hC0000000, fa, fz);
        run_frame(1'b0, 32'h0, 32'h0, fa, fz);
        strobe(5, 32'h1, 32'h2);
        strobe(60, 32'h3, 32'h4);
        check("pre_rst_overrun", 64'(overrun_a), 64'd1);
        check("pre_rst_underrun", 64'(cnt_a), 64'd1);
        goto_phase(70);
        reset = 1'b1;
        step();
        check("mid_rst_outputs", {59'd0, bck_out_a, lrck_a, sdata_a, overrun_a, muted_a}, 64'd0);
        check("mid_rst_underrun", 64'(cnt_a), 64'd0);
        step();
        reset = 1'b0;
        mute = 1'b0;
        run_frame(1'b1, 32'h40000000, 32'h55555555, fa, fz);
        check("mid_rst_zeros", fa, 64'd0);
        run_frame(1'b0, 32'h0, 32'h0, fa, fz);
        check("mid_rst_unity", fa, 64'h40000000_55555555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
